rr_grant_sequencer: RTL and testbench
=====================================

// Module: rr_grant_sequencer
// PURPOSE
//  Four-way round-robin arbiter directly upstream of the 2-to-4 decoder
//  (twotofourdec).
//  - Samples four request lines and picks one requester.
//  - Holds a registered 2-bit grant index; it drives the decoder's y input
//    so the decoder produces the one-hot enable.
//  - A hold counter caps grant length so no requester can starve the others.
// PARAMETERS
//  MAX_HOLD  8  maximum cycles a single grant may stay asserted (legal range 1..2**CW-1)
//  CW        4  hold-counter width; must satisfy 2**CW > MAX_HOLD
// PORTS
//  clk          in   1  single clock; all state changes on the rising edge
//  rst          in   1  asynchronous, active-high reset
//  req          in   4  request per requester; bit n = requester n
//  done         in   1  current grant holder finished; sampled only in GRANT
//  grant_idx    out  2  registered index of granted requester; connects to decoder y
//  grant_valid  out  1  high while grant_idx is a live grant
//  timeout      out  1  one-cycle pulse when a grant is forcibly ended by MAX_HOLD
// BEHAVIOUR
//  Reset (async, takes effect immediately without a clock edge):
//   grant_idx=0, grant_valid=0, timeout=0, state=IDLE, ptr=0, cnt=0.
//  States: IDLE, GRANT.
//  IDLE:
//   - If req==0: stay in IDLE; grant_valid=0.
//   - Otherwise the winner is the first set bit of req, searching ptr, ptr+1,
//     ptr+2, ptr+3 (mod 4).
//   - On the next edge: grant_idx=winner, grant_valid=1, cnt=0, state=GRANT.
//   - Latency from req sampled to grant_valid high is 1 cycle.
//  GRANT: release condition evaluated every cycle:
//   - done=1, OR req[grant_idx]=0 (requester dropped), OR cnt==MAX_HOLD-1.
//   - No release: cnt<=cnt+1; grant_idx and grant_valid held.
//   - Release: on that edge grant_valid<=0, state<=IDLE,
//     ptr<=grant_idx+1 (3 wraps to 0), cnt<=0.
//   - timeout<=1 for exactly one cycle only if the release was caused solely
//     by cnt==MAX_HOLD-1.
//   - If done or a dropped req coincides with the count limit: no timeout pulse.
//   - grant_valid is therefore high for at most MAX_HOLD consecutive cycles.
//  Arbitration gap: every release is followed by at least one cycle with
//   grant_valid=0, because IDLE arbitrates on the following edge.
//  Changes on non-granted req bits during GRANT are ignored.
//  done is ignored while in IDLE.
//  grant_idx keeps its last value while grant_valid=0; only reset clears it.
//  timeout is 0 in every cycle other than the single pulse cycle.
//  No combinational path from any input to any output; all outputs registered.
// TESTING
//  1 rst=1 with no clock edge -> grant_valid=0, grant_idx=0, timeout=0.
//    Repeat mid-GRANT: outputs clear asynchronously; after release, req=4'b1000
//    -> grant_idx=3 (search starts at ptr=0).
//  2 req=4'b0100 from IDLE -> next cycle grant_valid=1, grant_idx=2.
//    Then done=1 for one cycle -> grant_valid=0 on the following cycle, timeout=0.
//  3 req=4'b1111 held, done pulsed once per grant -> grant_idx sequence
//    0,1,2,3,0, with one grant_valid=0 cycle between each grant.
//  4 MAX_HOLD=8, req=4'b0010 held, done=0 -> grant_valid high exactly 8 cycles,
//    then timeout=1 for 1 cycle; the next grant is grant_idx=1 again.
//  5 Grant idx 3 released (ptr wraps to 0), then req=4'b1001 -> grant_idx=0.
//    Also: done=1 on the same cycle cnt reaches MAX_HOLD-1 -> release with timeout=0.
//  6 During grant to 1, req goes 4'b0010 -> 4'b0000 -> grant_valid drops on
//    the next edge, timeout=0; other req bits toggled mid-grant have no effect.

Source files
------------

// File: rtl/rr_grant_sequencer.sv
// Four-way round-robin arbiter feeding the 2-to-4 decoder. A registered grant index
// is held until done, the holder drops its request, or the hold limit expires.
module rr_grant_sequencer #(
  parameter int MAX_HOLD = 8,
  parameter int CW       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] grant_idx,
  output logic       grant_valid,
  output logic       timeout
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [CW-1:0] LP_LIMIT = CW'(MAX_HOLD - 1);

  state_t        r_state;
  logic [1:0]    r_ptr;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_grant_idx;
  logic          r_grant_valid;
  logic          r_timeout;

  state_t        w_state_nxt;
  logic [1:0]    w_ptr_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [1:0]    w_idx_nxt;
  logic          w_valid_nxt;
  logic          w_timeout_nxt;
  logic          w_at_limit;
  logic          w_holder_done;
  logic          w_release;
  logic [1:0]    w_winner;

  // First set request bit at or after the rotating start position.
  function automatic logic [1:0] f_pick(input logic [3:0] req_v, input logic [1:0] start);
    logic [1:0] idx;
    logic [1:0] win;
    logic       found;
    win   = start;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = start + 2'(k);
      if (!found && req_v[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  assign w_winner      = f_pick(req, r_ptr);
  assign w_at_limit    = (r_cnt == LP_LIMIT);
  assign w_holder_done = done | ~req[r_grant_idx];
  assign w_release     = w_holder_done | w_at_limit;

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = r_cnt;
    w_idx_nxt     = r_grant_idx;
    w_valid_nxt   = r_grant_valid;
    w_timeout_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (req != 4'b0000) begin
          w_idx_nxt   = w_winner;
          w_valid_nxt = 1'b1;
          w_cnt_nxt   = {CW{1'b0}};
          w_state_nxt = GRANT;
        end else begin
          w_valid_nxt = 1'b0;
        end
      end
      GRANT: begin
        if (w_release) begin
          w_valid_nxt   = 1'b0;
          w_state_nxt   = IDLE;
          w_ptr_nxt     = r_grant_idx + 2'd1;
          w_cnt_nxt     = {CW{1'b0}};
          // A pulse only when the limit alone forced the release.
          w_timeout_nxt = w_at_limit & ~w_holder_done;
        end else begin
          w_cnt_nxt = r_cnt + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_valid_nxt = 1'b0;
        w_cnt_nxt   = {CW{1'b0}};
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_ptr         <= 2'd0;
      r_cnt         <= {CW{1'b0}};
      r_grant_idx   <= 2'd0;
      r_grant_valid <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_ptr         <= w_ptr_nxt;
      r_cnt         <= w_cnt_nxt;
      r_grant_idx   <= w_idx_nxt;
      r_grant_valid <= w_valid_nxt;
      r_timeout     <= w_timeout_nxt;
    end
  end

  assign grant_idx   = r_grant_idx;
  assign grant_valid = r_grant_valid;
  assign timeout     = r_timeout;

endmodule

// File: tb/tb_rr_grant_sequencer.sv
// Bench for rr_grant_sequencer: vector table, directed corner sequences, and
// randomized traffic compared against a cycle-level behavioural model.
module tb_rr_grant_sequencer;

  localparam int MAX_HOLD = 8;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [1:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  int n_tests;
  int n_fail;

  rr_grant_sequencer #(.MAX_HOLD(MAX_HOLD), .CW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .done       (done),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: who holds the grant, how many cycles it has been held, where the search starts.
  logic m_valid;
  logic m_timeout;
  int   m_last;
  int   m_start;
  int   m_held;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid   <= 1'b0;
      m_timeout <= 1'b0;
      m_last    <= 0;
      m_start   <= 0;
      m_held    <= 0;
    end else if (!m_valid) begin
      m_timeout <= 1'b0;
      if (req != 4'b0000) begin
        int  w;
        bit  found;
        w = 0;
        found = 0;
        for (int k = 0; k < 4; k++) begin
          if (!found && req[(m_start + k) % 4]) begin
            w = (m_start + k) % 4;
            found = 1;
          end
        end
        m_valid <= 1'b1;
        m_last  <= w;
        m_held  <= 1;
      end
    end else begin
      bit finished;
      bit limit;
      finished = done || !req[m_last];
      limit    = (m_held == MAX_HOLD);
      if (finished || limit) begin
        m_valid   <= 1'b0;
        m_start   <= (m_last + 1) % 4;
        m_timeout <= limit && !finished;
        m_held    <= 0;
      end else begin
        m_held    <= m_held + 1;
        m_timeout <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge: drive inputs, cross one rising edge, return at the next falling edge.
  task automatic step(input logic r, input logic [3:0] rq, input logic d);
    rst  = r;
    req  = rq;
    done = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic       ev;
    logic [1:0] ei;
    logic       et;
  } vec_t;

  vec_t tbl[19];

  initial begin
    int hold;
    int seen_to;
    logic [3:0] rq;

    n_tests = 0;
    n_fail  = 0;
    rst  = 1'b0;
    req  = 4'b0000;
    done = 1'b0;

    tbl[0]  = '{1'b0, 4'b0100, 1'b0, 1'b1, 2'd2, 1'b0};
    tbl[1]  = '{1'b0, 4'b0100, 1'b1, 1'b0, 2'd2, 1'b0};
    tbl[2]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 2'd2, 1'b0};
    tbl[3]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0};
    tbl[4]  = '{1'b0, 4'b1111, 1'b0, 1'b1, 2'd0, 1'b0};
    tbl[5]  = '{1'b0, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b0};
    tbl[6]  = '{1'b0, 4'b1111, 1'b0, 1'b1, 2'd1, 1'b0};
    tbl[7]  = '{1'b0, 4'b1111, 1'b1, 1'b0, 2'd1, 1'b0};
    tbl[8]  = '{1'b0, 4'b1111, 1'b0, 1'b1, 2'd2, 1'b0};
    tbl[9]  = '{1'b0, 4'b1111, 1'b1, 1'b0, 2'd2, 1'b0};
    tbl[10] = '{1'b0, 4'b1111, 1'b0, 1'b1, 2'd3, 1'b0};
    tbl[11] = '{1'b0, 4'b1111, 1'b1, 1'b0, 2'd3, 1'b0};
    tbl[12] = '{1'b0, 4'b1111, 1'b0, 1'b1, 2'd0, 1'b0};
    tbl[13] = '{1'b0, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b0};
    tbl[14] = '{1'b0, 4'b0010, 1'b0, 1'b1, 2'd1, 1'b0};
    tbl[15] = '{1'b0, 4'b1011, 1'b0, 1'b1, 2'd1, 1'b0};
    tbl[16] = '{1'b0, 4'b0110, 1'b0, 1'b1, 2'd1, 1'b0};
    tbl[17] = '{1'b0, 4'b0000, 1'b0, 1'b0, 2'd1, 1'b0};
    tbl[18] = '{1'b0, 4'b0000, 1'b0, 1'b0, 2'd1, 1'b0};

    // Asynchronous reset before any clock edge.
    #1 rst = 1'b1;
    #1;
    chk("rst_valid", {3'b000, grant_valid}, 4'h0);
    chk("rst_idx",   {2'b00, grant_idx},    4'h0);
    chk("rst_to",    {3'b000, timeout},     4'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      step(tbl[i].rst, tbl[i].req, tbl[i].done);
      chk($sformatf("vec%0d_valid", i), {3'b000, grant_valid}, {3'b000, tbl[i].ev});
      chk($sformatf("vec%0d_idx", i),   {2'b00, grant_idx},    {2'b00, tbl[i].ei});
      chk($sformatf("vec%0d_to", i),    {3'b000, timeout},     {3'b000, tbl[i].et});
    end

    // Hold limit: requester 1 never finishes.
    step(1'b1, 4'b0000, 1'b0);
    hold = 0;
    seen_to = 0;
    step(1'b0, 4'b0010, 1'b0);
    for (int c = 0; c < 20 && seen_to == 0; c++) begin
      if (grant_valid) hold++;
      if (timeout) seen_to = 1;
      else step(1'b0, 4'b0010, 1'b0);
    end
    chk("hold_len",   4'(hold),    4'(MAX_HOLD));
    chk("hold_to",    4'(seen_to), 4'h1);
    chk("hold_gap",   {3'b000, grant_valid}, 4'h0);
    step(1'b0, 4'b0010, 1'b0);
    chk("regrant_valid", {3'b000, grant_valid}, 4'h1);
    chk("regrant_idx",   {2'b00, grant_idx},    4'h1);
    chk("regrant_to",    {3'b000, timeout},     4'h0);

    // Pointer wrap after requester 3, then done coinciding with the limit.
    step(1'b1, 4'b0000, 1'b0);
    step(1'b0, 4'b1000, 1'b0);
    chk("wrap_idx3", {2'b00, grant_idx}, 4'h3);
    step(1'b0, 4'b1000, 1'b1);
    step(1'b0, 4'b1001, 1'b0);
    chk("wrap_idx0",   {2'b00, grant_idx},    4'h0);
    chk("wrap_valid",  {3'b000, grant_valid}, 4'h1);
    for (int c = 0; c < MAX_HOLD - 1; c++) step(1'b0, 4'b1001, 1'b0);
    chk("lim_still_valid", {3'b000, grant_valid}, 4'h1);
    step(1'b0, 4'b1001, 1'b1);
    chk("lim_done_valid", {3'b000, grant_valid}, 4'h0);
    chk("lim_done_to",    {3'b000, timeout},     4'h0);

    // Asynchronous reset in the middle of a grant.
    step(1'b1, 4'b0000, 1'b0);
    step(1'b0, 4'b0100, 1'b0);
    chk("mid_pre_valid", {3'b000, grant_valid}, 4'h1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {3'b000, grant_valid}, 4'h0);
    chk("mid_rst_idx",   {2'b00, grant_idx},    4'h0);
    @(negedge clk);
    step(1'b0, 4'b1000, 1'b0);
    chk("mid_after_idx",   {2'b00, grant_idx},    4'h3);
    chk("mid_after_valid", {3'b000, grant_valid}, 4'h1);

    // Randomized traffic against the model.
    step(1'b1, 4'b0000, 1'b0);
    rq = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
      step(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0, rq, ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0);
      chk("rnd_valid", {3'b000, grant_valid}, {3'b000, m_valid});
      chk("rnd_idx",   {2'b00, grant_idx},    4'(m_last));
      chk("rnd_to",    {3'b000, timeout},     {3'b000, m_timeout});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
